// File: rtl/audio_pll_sup_pkg.sv
// Shared encodings and widths for the audio PLL lock supervisor.
package audio_pll_sup_pkg;

  localparam int unsigned LOSS_CNT_W = 8;
  localparam int unsigned RETRY_W    = 3;

  // Encodings are visible on the debug state port and must stay fixed.
  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StSettle   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/audio_pll_supervisor.sv
// Audio PLL reset sequencer: pulses the PLL reset, qualifies lock over a settle window,
// releases the audio reset, retries on timeout and latches a fault after repeated failures.
module audio_pll_supervisor
  import audio_pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned TIMER_W       = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  restart,
  output logic                  pll_rst,
  output logic                  audio_rst_n,
  output logic                  pll_ready,
  output logic                  fault,
  output logic [RETRY_W-1:0]    retry_cnt,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            state
);

  localparam logic [TIMER_W-1:0] RstLast    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TimeoutLast = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SettleLast = TIMER_W'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    pll_rst_q, pll_rst_d;
  logic                    audio_rst_n_q, audio_rst_n_d;
  logic                    pll_ready_q, pll_ready_d;
  logic                    fault_q, fault_d;
  logic                    locked_s;
  logic                    retry_last;

  sync_2ff u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  assign retry_last = ((32'(retry_q) + 32'd1) == MAX_RETRIES);

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q       <= StPllRst;
      timer_q       <= '0;
      retry_q       <= '0;
      loss_q        <= '0;
      pll_rst_q     <= 1'b1;
      audio_rst_n_q <= 1'b0;
      pll_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      loss_q        <= loss_d;
      pll_rst_q     <= pll_rst_d;
      audio_rst_n_q <= audio_rst_n_d;
      pll_ready_q   <= pll_ready_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = StPllRst;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (timer_q == RstLast) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        StWaitLock: begin
          if (locked_s) begin
            state_d = StSettle;
            timer_d = '0;
          end else if (timer_q == TimeoutLast) begin
            timer_d = '0;
            if (retry_last) begin
              state_d = StFault;
            end else begin
              state_d = StPllRst;
              retry_d = retry_q + RETRY_W'(1);
            end
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        StSettle: begin
          if (!locked_s) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else if (timer_q == SettleLast) begin
            state_d = StRun;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        StRun: begin
          if (!locked_s) begin
            state_d = StPllRst;
            timer_d = '0;
            if (loss_q != '1) begin
              loss_d = loss_q + LOSS_CNT_W'(1);
            end
          end
        end
        StFault: begin
          timer_d = '0;
        end
        default: begin
          state_d = StPllRst;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    pll_rst_d     = (state_d == StPllRst) || (state_d == StFault);
    audio_rst_n_d = (state_d == StRun);
    pll_ready_d   = (state_d == StRun);
    fault_d       = (state_d == StFault);
  end

  assign pll_rst       = pll_rst_q;
  assign audio_rst_n   = audio_rst_n_q;
  assign pll_ready     = pll_ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// Directed self-checking bench for audio_pll_supervisor with shortened timing parameters.
module tb_audio_pll_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       audio_rst_n;
  logic       pll_ready;
  logic       fault;
  logic [2:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  audio_pll_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .SETTLE_CYCLES (8),
    .MAX_RETRIES   (3),
    .TIMER_W       (16)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .restart       (restart),
    .pll_rst       (pll_rst),
    .audio_rst_n   (audio_rst_n),
    .pll_ready     (pll_ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    tick(3);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL rst_pll_rst: got %0b expected 1", pll_rst); end
    n_cmp++; if (audio_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_audio: got %0b expected 0", audio_rst_n); end
    n_cmp++; if (pll_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b expected 0", pll_ready); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %0b expected 0", fault); end
    n_cmp++; if (retry_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_retry: got %0d expected 0", retry_cnt); end
    n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_loss: got %0d expected 0", lock_loss_cnt); end
  endtask

  task automatic test_bringup();
    logic [2:0] exp_st;
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      exp_st = (c < 4) ? 3'd0 : 3'd1;
      n_cmp++; if (state !== exp_st) begin n_bad++; $display("FAIL up_state c%0d: got %0d expected %0d", c, state, exp_st); end
      n_cmp++; if (pll_rst !== (c < 4)) begin n_bad++; $display("FAIL up_pll_rst c%0d: got %0b expected %0b", c, pll_rst, (c < 4)); end
    end
    pll_locked = 1'b1;
    tick(2);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL up_sync_lat: got %0d expected 1", state); end
    tick(1);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL up_settle_entry: got %0d expected 2", state); end
    tick(7);
    n_cmp++; if (audio_rst_n !== 1'b0) begin n_bad++; $display("FAIL up_audio_early: got %0b expected 0", audio_rst_n); end
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL up_settle_end: got %0d expected 2", state); end
    tick(1);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL up_run: got %0d expected 3", state); end
    n_cmp++; if (audio_rst_n !== 1'b1) begin n_bad++; $display("FAIL up_audio: got %0b expected 1", audio_rst_n); end
    n_cmp++; if (pll_ready !== 1'b1) begin n_bad++; $display("FAIL up_ready: got %0b expected 1", pll_ready); end
    n_cmp++; if (retry_cnt !== 3'd0) begin n_bad++; $display("FAIL up_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_settle_glitch();
    do_reset();
    tick(5);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(2);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL gl_in_settle: got %0d expected 2", state); end
    pll_locked = 1'b1;
    tick(1);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL gl_back_wait: got %0d expected 1", state); end
    tick(2);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL gl_resettle: got %0d expected 2", state); end
    tick(7);
    n_cmp++; if (audio_rst_n !== 1'b0) begin n_bad++; $display("FAIL gl_audio_early: got %0b expected 0", audio_rst_n); end
    tick(1);
    n_cmp++; if (audio_rst_n !== 1'b1) begin n_bad++; $display("FAIL gl_audio: got %0b expected 1", audio_rst_n); end
    n_cmp++; if (retry_cnt !== 3'd0) begin n_bad++; $display("FAIL gl_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_timeouts();
    logic [2:0] exp_st;
    logic [2:0] exp_rt;
    logic       exp_pr;
    do_reset();
    for (int c = 1; c <= 75; c++) begin
      tick(1);
      exp_st = (c < 4) ? 3'd0 : (c < 24) ? 3'd1 : (c < 28) ? 3'd0 :
               (c < 48) ? 3'd1 : (c < 52) ? 3'd0 : (c < 72) ? 3'd1 : 3'd4;
      exp_rt = (c < 24) ? 3'd0 : (c < 48) ? 3'd1 : 3'd2;
      exp_pr = (exp_st != 3'd1);
      n_cmp++; if (state !== exp_st) begin n_bad++; $display("FAIL to_state c%0d: got %0d expected %0d", c, state, exp_st); end
      n_cmp++; if (retry_cnt !== exp_rt) begin n_bad++; $display("FAIL to_retry c%0d: got %0d expected %0d", c, retry_cnt, exp_rt); end
      n_cmp++; if (pll_rst !== exp_pr) begin n_bad++; $display("FAIL to_pll_rst c%0d: got %0b expected %0b", c, pll_rst, exp_pr); end
      n_cmp++; if (fault !== (exp_st == 3'd4)) begin n_bad++; $display("FAIL to_fault c%0d: got %0b expected %0b", c, fault, (exp_st == 3'd4)); end
      n_cmp++; if (audio_rst_n !== 1'b0) begin n_bad++; $display("FAIL to_audio c%0d: got %0b expected 0", c, audio_rst_n); end
    end
  endtask

  task automatic test_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rs_state: got %0d expected 0", state); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rs_fault: got %0b expected 0", fault); end
    n_cmp++; if (retry_cnt !== 3'd0) begin n_bad++; $display("FAIL rs_retry: got %0d expected 0", retry_cnt); end
    tick(3);
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL rs_pll_rst_hold: got %0b expected 1", pll_rst); end
    tick(1);
    n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL rs_pll_rst_end: got %0b expected 0", pll_rst); end
    pll_locked = 1'b1;
    tick(10);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL rs_settle: got %0d expected 2", state); end
    tick(1);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL rs_run: got %0d expected 3", state); end
    n_cmp++; if (audio_rst_n !== 1'b1) begin n_bad++; $display("FAIL rs_audio: got %0b expected 1", audio_rst_n); end
  endtask

  task automatic test_lock_loss();
    logic [7:0] exp_loss;
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    n_cmp++; if (audio_rst_n !== 1'b1) begin n_bad++; $display("FAIL ll_audio_m1: got %0b expected 1", audio_rst_n); end
    tick(1);
    n_cmp++; if (audio_rst_n !== 1'b0) begin n_bad++; $display("FAIL ll_audio_m2: got %0b expected 0", audio_rst_n); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL ll_pll_rst_m2: got %0b expected 1", pll_rst); end
    n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_bad++; $display("FAIL ll_count1: got %0d expected 1", lock_loss_cnt); end
    tick(12);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL ll_resettle: got %0d expected 2", state); end
    tick(1);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL ll_rerun: got %0d expected 3", state); end
    for (int k = 2; k <= 260; k++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(2);
      exp_loss = (k < 255) ? 8'(k) : 8'd255;
      n_cmp++; if (lock_loss_cnt !== exp_loss) begin n_bad++; $display("FAIL ll_count k%0d: got %0d expected %0d", k, lock_loss_cnt, exp_loss); end
      for (int i = 0; i < 40 && state !== 3'd3; i++) tick(1);
      n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL ll_wait_run k%0d: got %0d expected 3", k, state); end
    end
  endtask

  task automatic test_priority_reset();
    pll_locked = 1'b0;
    tick(3);
    for (int i = 0; i < 10 && state !== 3'd1; i++) tick(1);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL pr_wait: got %0d expected 1", state); end
    tick(19);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL pr_last_wait: got %0d expected 1", state); end
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL pr_state: got %0d expected 0", state); end
    n_cmp++; if (retry_cnt !== 3'd0) begin n_bad++; $display("FAIL pr_retry: got %0d expected 0", retry_cnt); end
    n_cmp++; if (lock_loss_cnt !== 8'd255) begin n_bad++; $display("FAIL pr_loss_kept: got %0d expected 255", lock_loss_cnt); end
    pll_locked = 1'b1;
    for (int i = 0; i < 60 && state !== 3'd3; i++) tick(1);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL pr_wait_run: got %0d expected 3", state); end
    rst_n = 1'b0;
    tick(1);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL mr_state: got %0d expected 0", state); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL mr_pll_rst: got %0b expected 1", pll_rst); end
    n_cmp++; if (audio_rst_n !== 1'b0) begin n_bad++; $display("FAIL mr_audio: got %0b expected 0", audio_rst_n); end
    n_cmp++; if (pll_ready !== 1'b0) begin n_bad++; $display("FAIL mr_ready: got %0b expected 0", pll_ready); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL mr_fault: got %0b expected 0", fault); end
    n_cmp++; if (retry_cnt !== 3'd0) begin n_bad++; $display("FAIL mr_retry: got %0d expected 0", retry_cnt); end
    n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_bad++; $display("FAIL mr_loss: got %0d expected 0", lock_loss_cnt); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    test_reset();
    test_bringup();
    test_settle_glitch();
    test_timeouts();
    test_restart();
    test_lock_loss();
    test_priority_reset();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_pll_supervisor.md
Name: audio_pll_supervisor

Overview:
Lock supervisor and reset sequencer for the audio clock PLL, which produces the 12.288 MHz codec clocks from the 50 MHz reference.
- Runs in the refclk domain.
- Drives the PLL reset.
- Qualifies the PLL locked output. It synchronises it and requires it to stay high for a settle window.
- Releases the audio-domain reset only after that qualification.
- Retries on lock timeout, enters a sticky FAULT after repeated failures, and counts lock losses for status readback.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT, 50000, cycles to wait for lock before retrying (1 ms at 50 MHz)
SETTLE_CYCLES, 1024, cycles locked must stay high before audio reset release (>=1)
MAX_RETRIES, 4, consecutive failed lock attempts before FAULT (>=1)
TIMER_W, 16, timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)-1

Ports:
refclk  in  1  50 MHz reference clock; the only clock
rst_n  in  1  synchronous active-low reset
pll_locked  in  1  PLL locked output; asynchronous to refclk
restart  in  1  single-cycle request to re-run the PLL sequence and clear FAULT
pll_rst  out  1  active-high reset to the PLL
audio_rst_n  out  1  active-low reset for audio logic; high only in RUN
pll_ready  out  1  high only in RUN
fault  out  1  high only in FAULT
retry_cnt  out  3  failed attempts in the current sequence
lock_loss_cnt  out  8  number of lock losses from RUN; saturates at 255
state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset and register rules:
  - All outputs are registered.
  - While rst_n=0 at an edge: state=PLL_RST, timer=0, pll_rst=1, audio_rst_n=0, pll_ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchroniser flops=0.
  - Reset mid-operation aborts any state, with the same values.
- Synchroniser: pll_locked passes through a 2-flop synchroniser to give locked_s. The FSM uses only locked_s.
- States: PLL_RST=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4.
- PLL_RST:
  - pll_rst=1.
  - The timer counts 0..RST_CYCLES-1.
  - On timer=RST_CYCLES-1, go to WAIT_LOCK with timer=0.
  - pll_rst is therefore high for exactly RST_CYCLES cycles per attempt.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to SETTLE with timer=0.
  - Otherwise, if timer=LOCK_TIMEOUT-1, the attempt has failed:
    - If retry_cnt+1=MAX_RETRIES, go to FAULT.
    - Otherwise increment retry_cnt and go to PLL_RST.
  - Otherwise increment the timer.
- SETTLE:
  - If locked_s=0, go back to WAIT_LOCK with timer=0. retry_cnt is unchanged.
  - Otherwise, if timer=SETTLE_CYCLES-1, go to RUN and clear retry_cnt.
- RUN:
  - audio_rst_n=1, pll_ready=1.
  - If locked_s=0, go to PLL_RST with timer=0, and increment lock_loss_cnt (it saturates at 255).
- FAULT:
  - pll_rst=1, fault=1, audio_rst_n=0.
  - The state holds until restart.
- restart:
  - When sampled high in any state, it goes to PLL_RST with timer=0 and retry_cnt=0.
  - restart takes priority over every other transition in the same cycle.
  - restart does not clear lock_loss_cnt; only rst_n clears it.
- Latency:
  - pll_locked is sampled high at edge N and stays high from then on. locked_s=1 after edge N+1. SETTLE is entered at edge N+2. RUN and audio_rst_n=1 occur at edge N+SETTLE_CYCLES+2.
  - pll_locked is sampled low at edge M while in RUN. audio_rst_n=0 and pll_rst=1 occur at edge M+2.
- Glitches: a locked glitch shorter than one refclk period may be missed. A glitch that reaches locked_s restarts SETTLE or forces PLL_RST from RUN as above.

Decomposition:
- Package audio_pll_sup_pkg holds:
  - the state encoding constants (PLL_RST..FAULT, 3 bits);
  - the LOSS_CNT_W=8 and RETRY_W=3 width constants.
- Sub-module sync_2ff is a generic single-bit 2-flop synchroniser with a synchronous active-low reset to 0. It is reused for pll_locked.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=3.
1. Clean bring-up: release rst_n, raise pll_locked 10 cycles later -> pll_rst high for 4 cycles. audio_rst_n and pll_ready rise 10 edges after locked is first sampled. retry_cnt=0.
2. Settle glitch: pll_locked high for 5 cycles, low for 2, then high -> FSM returns to WAIT_LOCK, then SETTLE restarts. audio_rst_n rises 10 edges after the final rise. retry_cnt stays 0.
3. Timeouts to FAULT: hold pll_locked=0 -> three pll_rst pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles. retry_cnt goes 1, then 2, then FAULT with fault=1 and pll_rst held 1. audio_rst_n stays 0.
4. Restart from FAULT: pulse restart for 1 cycle, then raise pll_locked -> fault=0, retry_cnt=0, 4-cycle pll_rst, then normal RUN.
5. Lock loss in RUN: drop pll_locked for 1 cycle while in RUN -> audio_rst_n=0 and pll_rst=1 2 edges later. lock_loss_cnt increments by 1 and the FSM re-sequences. Force 260 losses -> lock_loss_cnt=255.
6. Priority and reset: assert restart in the same cycle as a WAIT_LOCK timeout -> PLL_RST with retry_cnt=0, not incremented. Assert rst_n=0 for 1 cycle while in RUN -> all outputs return to their reset values at the next edge.
